// File: rtl/mdr_result_stage.sv
// ---------------------------------------------------------------------------
// mdr_result_stage
// Result stage of the multiply/divide/root datapath. It captures the raw core
// result on i_flag, formats it by operation mode (MUL range check with optional
// saturation, DIV divide-by-zero marking, SQRT pass-through) and queues it in a
// small FIFO. The FIFO head is held in registers and offered with valid/ack.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   i_flag         one-cycle strobe: core result valid
//   i_mode         00 MUL, 01 DIV, 10 SQRT, 11 reserved (sampled with i_flag)
//   i_data         signed raw result, 2*DW+1 bits, bit 0 is a discarded guard
//   i_div_zero     DIV divisor was zero (sampled with i_flag)
//   i_ack          consumer accepts the head entry
//   o_ready        head entry valid
//   o_data/o_rem   primary / secondary result of the head entry
//   o_ovf/o_dbz    MUL overflow / DIV by zero of the head entry
//   o_full         FIFO holds DEPTH entries; core must stall
//   o_count        exact occupancy
//   o_err          sticky: a result was dropped or a reserved mode arrived
// ---------------------------------------------------------------------------
module mdr_result_stage #(
    parameter int unsigned DW     = 32,
    parameter int unsigned DEPTH  = 2,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flag,
    input  logic [1:0]                   i_mode,
    input  logic [2*DW:0]                i_data,
    input  logic                         i_div_zero,
    input  logic                         i_ack,
    output logic                         o_ready,
    output logic [DW-1:0]                o_data,
    output logic [DW-1:0]                o_rem,
    output logic                         o_ovf,
    output logic                         o_dbz,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [1:0] MODE_MUL  = 2'b00;
    localparam logic [1:0] MODE_DIV  = 2'b01;
    localparam logic [1:0] MODE_SQRT = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [DW-1:0] rem;
        logic          ovf;
        logic          dbz;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    entry_t          r_head;
    logic            r_ready;
    logic            r_full;
    logic            r_err;

    logic [2*DW-1:0] w_p;
    logic [DW:0]     w_hi_bits;
    logic            w_mul_ovf;
    entry_t          w_fmt;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [CW-1:0]   w_count_next;
    logic            w_head_load;
    entry_t          w_head_next;
    logic [PW-1:0]   w_rd_ptr_inc;

    // Result formatting by mode; P drops the Booth guard bit
    always_comb begin
        w_p       = i_data[2*DW:1];
        w_hi_bits = w_p[2*DW-1:DW-1];
        // Product fits DW signed bits only if the top DW+1 bits are a sign run
        w_mul_ovf = !((&w_hi_bits) || !(|w_hi_bits));
        w_fmt      = '0;
        w_fmt.data = w_p[DW-1:0];
        w_fmt.rem  = w_p[2*DW-1:DW];
        case (i_mode)
            MODE_MUL: begin
                w_fmt.ovf = w_mul_ovf;
                if (w_mul_ovf && SAT_EN) begin
                    w_fmt.data = w_p[2*DW-1] ? {1'b1, {(DW-1){1'b0}}}
                                             : {1'b0, {(DW-1){1'b1}}};
                end
            end
            MODE_DIV: begin
                if (i_div_zero) begin
                    w_fmt.dbz  = 1'b1;
                    w_fmt.data = '1;
                end
            end
            MODE_SQRT: begin
                w_fmt.data = w_p[DW-1:0];
            end
            default: begin
                w_fmt = '0;
            end
        endcase
    end

    // Push/pop decision and next head selection
    always_comb begin
        w_pop        = r_ready && i_ack;
        w_push       = i_flag && (i_mode != MODE_RSVD) &&
                       ((r_count < CW'(DEPTH)) || w_pop);
        w_drop       = i_flag && !w_push;
        w_count_next = CW'(r_count + CW'(w_push) - CW'(w_pop));
        w_rd_ptr_inc = PW'(r_rd_ptr + 1'b1);
        w_head_load  = 1'b0;
        w_head_next  = r_head;
        if (w_pop) begin
            // Second entry (already in storage) or the incoming one becomes head
            if (r_count >= CW'(2)) begin
                w_head_load = 1'b1;
                w_head_next = r_mem[w_rd_ptr_inc];
            end else if (w_push) begin
                w_head_load = 1'b1;
                w_head_next = w_fmt;
            end
        end else if ((r_count == '0) && w_push) begin
            w_head_load = 1'b1;
            w_head_next = w_fmt;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_fmt;
        end
    end

    // Pointers, occupancy, status and registered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_ready  <= 1'b0;
            r_full   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= PW'(r_wr_ptr + 1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (w_head_load) begin
                r_head <= w_head_next;
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next != '0);
            r_full  <= (w_count_next == CW'(DEPTH));
            r_err   <= r_err || w_drop;
        end
    end

    assign o_ready = r_ready;
    assign o_data  = r_head.data;
    assign o_rem   = r_head.rem;
    assign o_ovf   = r_head.ovf;
    assign o_dbz   = r_head.dbz;
    assign o_full  = r_full;
    assign o_count = r_count;
    assign o_err   = r_err;

endmodule

// File: tb/tb_mdr_result_stage.sv
// ---------------------------------------------------------------------------
// tb_mdr_result_stage
// Directed bench for mdr_result_stage. Two instances share the stimulus: one
// saturating (SAT_EN=1) and one wrapping (SAT_EN=0). Expected entries are
// produced by an arithmetic model, queued on push and compared on delivery.
// ---------------------------------------------------------------------------
module tb_mdr_result_stage;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    localparam logic [1:0] M_MUL  = 2'b00;
    localparam logic [1:0] M_DIV  = 2'b01;
    localparam logic [1:0] M_SQRT = 2'b10;
    localparam logic [1:0] M_RSVD = 2'b11;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d0;
        logic [31:0] rem;
        logic        ovf;
        logic        dbz;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_flag;
    logic [1:0]    i_mode;
    logic [2*DW:0] i_data;
    logic          i_div_zero;
    logic          i_ack;

    logic          o1_ready, o1_ovf, o1_dbz, o1_full, o1_err;
    logic [DW-1:0] o1_data, o1_rem;
    logic [CW-1:0] o1_count;
    logic          o0_ready, o0_ovf, o0_dbz, o0_full, o0_err;
    logic [DW-1:0] o0_data, o0_rem;
    logic [CW-1:0] o0_count;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t last;
    int   mcount;
    logic merr;

    always #5 clk = ~clk;

    mdr_result_stage #(.DW(DW), .DEPTH(DEPTH), .SAT_EN(1'b1)) u_sat (
        .clk(clk), .rst(rst), .i_flag(i_flag), .i_mode(i_mode), .i_data(i_data),
        .i_div_zero(i_div_zero), .i_ack(i_ack),
        .o_ready(o1_ready), .o_data(o1_data), .o_rem(o1_rem), .o_ovf(o1_ovf),
        .o_dbz(o1_dbz), .o_full(o1_full), .o_count(o1_count), .o_err(o1_err)
    );

    mdr_result_stage #(.DW(DW), .DEPTH(DEPTH), .SAT_EN(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .i_flag(i_flag), .i_mode(i_mode), .i_data(i_data),
        .i_div_zero(i_div_zero), .i_ack(i_ack),
        .o_ready(o0_ready), .o_data(o0_data), .o_rem(o0_rem), .o_ovf(o0_ovf),
        .o_dbz(o0_dbz), .o_full(o0_full), .o_count(o0_count), .o_err(o0_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected formatting derived from the integer value of the product
    function automatic exp_t model(input logic [1:0] mode, input logic [63:0] p,
                                   input logic dz);
        exp_t   e;
        longint sp;
        sp    = $signed(p);
        e.d1  = p[31:0];
        e.d0  = p[31:0];
        e.rem = p[63:32];
        e.ovf = 1'b0;
        e.dbz = 1'b0;
        if (mode == M_MUL && (sp > MAXV || sp < MINV)) begin
            e.ovf = 1'b1;
            e.d1  = (sp < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        if (mode == M_DIV && dz) begin
            e.dbz = 1'b1;
            e.d1  = 32'hFFFF_FFFF;
            e.d0  = 32'hFFFF_FFFF;
        end
        return e;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".count"},  64'(o1_count), 64'(mcount));
        chk({tag, ".count0"}, 64'(o0_count), 64'(mcount));
        chk({tag, ".ready"},  64'(o1_ready), 64'(mcount != 0));
        chk({tag, ".full"},   64'(o1_full),  64'(mcount == DEPTH));
        chk({tag, ".err"},    64'(o1_err),   64'(merr));
        chk({tag, ".err0"},   64'(o0_err),   64'(merr));
        if (mcount > 0) begin
            chk({tag, ".data"},  64'(o1_data), 64'(sb[0].d1));
            chk({tag, ".data0"}, 64'(o0_data), 64'(sb[0].d0));
            chk({tag, ".rem"},   64'(o1_rem),  64'(sb[0].rem));
            chk({tag, ".ovf"},   64'(o1_ovf),  64'(sb[0].ovf));
            chk({tag, ".ovf0"},  64'(o0_ovf),  64'(sb[0].ovf));
            chk({tag, ".dbz"},   64'(o1_dbz),  64'(sb[0].dbz));
        end else begin
            chk({tag, ".hold_data"},  64'(o1_data), 64'(last.d1));
            chk({tag, ".hold_data0"}, 64'(o0_data), 64'(last.d0));
            chk({tag, ".hold_rem"},   64'(o1_rem),  64'(last.rem));
        end
    endtask

    // One clock of stimulus, driven at negedge; model updated at the edge
    task automatic step(input string tag, input logic flag, input logic [1:0] mode,
                        input logic [63:0] p, input logic dz, input logic ack);
        exp_t e;
        bit   pop;
        bit   push;
        pop  = ack && (mcount > 0);
        push = flag && (mode != M_RSVD) && ((mcount < DEPTH) || pop);
        e    = model(mode, p, dz);
        i_flag     = flag;
        i_mode     = mode;
        i_data     = {p, 1'b1};
        i_div_zero = dz;
        i_ack      = ack;
        @(posedge clk);
        if (pop) begin
            last = sb.pop_front();
            mcount--;
        end
        if (push) begin
            sb.push_back(e);
            mcount++;
        end
        if (flag && !push) merr = 1'b1;
        @(negedge clk);
        i_flag     = 1'b0;
        i_ack      = 1'b0;
        i_div_zero = 1'b0;
        check_state(tag);
    endtask

    task automatic model_reset();
        sb.delete();
        mcount = 0;
        merr   = 1'b0;
        last   = '{d1: '0, d0: '0, rem: '0, ovf: 1'b0, dbz: 1'b0};
    endtask

    // Asynchronous reset raised between clock edges, checked before any edge
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 model_reset();
        check_state({tag, ".in_reset"});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_state({tag, ".after_reset"});
    endtask

    task automatic ack_one(input string tag);
        step(tag, 1'b0, M_MUL, 64'd0, 1'b0, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        i_flag     = 1'b0;
        i_mode     = M_MUL;
        i_data     = '0;
        i_div_zero = 1'b0;
        i_ack      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_state("reset");
        rst = 1'b0;
        @(negedge clk);
        check_state("idle");

        // MUL in range, including signed and boundary values
        step("mul42", 1'b1, M_MUL, 64'd42, 1'b0, 1'b0);
        ack_one("mul42.ack");
        step("mulneg", 1'b1, M_MUL, -64'sd35, 1'b0, 1'b0);
        ack_one("mulneg.ack");
        step("mulmax", 1'b1, M_MUL, 64'h0000_0000_7FFF_FFFF, 1'b0, 1'b0);
        ack_one("mulmax.ack");
        step("mulmin", 1'b1, M_MUL, -64'sd2147483648, 1'b0, 1'b0);
        ack_one("mulmin.ack");

        // MUL overflow: saturate vs wrap
        step("ovfpos", 1'b1, M_MUL, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
        ack_one("ovfpos.ack");
        step("ovfneg", 1'b1, M_MUL, -64'sh1_0000_0000, 1'b0, 1'b0);
        ack_one("ovfneg.ack");
        step("ovf80", 1'b1, M_MUL, 64'h0000_0000_8000_0000, 1'b0, 1'b0);
        ack_one("ovf80.ack");

        // DIV and SQRT
        step("div", 1'b1, M_DIV, {32'd3, 32'd5}, 1'b0, 1'b0);
        ack_one("div.ack");
        step("divz", 1'b1, M_DIV, {32'd3, 32'd5}, 1'b1, 1'b0);
        ack_one("divz.ack");
        step("sqrt", 1'b1, M_SQRT, {32'd7, 32'h0000_FFFF}, 1'b0, 1'b0);
        ack_one("sqrt.ack");

        // Back-pressure: third push dropped, then drain in order
        step("bpA", 1'b1, M_MUL, 64'd11, 1'b0, 1'b0);
        step("bpB", 1'b1, M_DIV, {32'd1, 32'd22}, 1'b0, 1'b0);
        step("bpC", 1'b1, M_MUL, 64'd33, 1'b0, 1'b0);
        ack_one("bp.ack1");
        ack_one("bp.ack2");
        ack_one("bp.ack_empty");

        // Full with simultaneous push and pop, then one-entry push and pop
        step("fA", 1'b1, M_MUL, 64'd101, 1'b0, 1'b0);
        step("fB", 1'b1, M_MUL, 64'd102, 1'b0, 1'b0);
        step("fD", 1'b1, M_SQRT, {32'd9, 32'd103}, 1'b0, 1'b1);
        ack_one("f.ack1");
        step("fE", 1'b1, M_MUL, 64'd104, 1'b0, 1'b1);
        ack_one("f.ack2");

        // Reserved mode only raises the sticky error
        async_reset("rst1");
        step("rsvd", 1'b1, M_RSVD, 64'd55, 1'b0, 1'b0);
        step("rsvd.idle", 1'b0, M_MUL, 64'd0, 1'b0, 1'b0);

        // Mid-stream reset with two entries queued
        step("mA", 1'b1, M_MUL, 64'd201, 1'b0, 1'b0);
        step("mB", 1'b1, M_MUL, 64'd202, 1'b0, 1'b0);
        async_reset("rst2");
        step("fresh", 1'b1, M_MUL, 64'd42, 1'b0, 1'b0);
        ack_one("fresh.ack");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mdr_result_stage.md
Name: mdr_result_stage

Overview:
Parametrised result stage for the multiply/divide/root (MDR) datapath. It captures the raw core result on a completion strobe and formats it per operation mode. MUL results are range-checked, with optional saturation. The block queues formatted results in a small FIFO and presents them to the consumer through a valid/ack handshake, with back-pressure toward the MDR core.

Parameters:
DW, 32, result word width; raw input is 2*DW+1 bits (Booth guard bit at LSB)
DEPTH, 2, output FIFO depth; power of two, >= 2
SAT_EN, 1, 1 = saturate MUL overflow, 0 = wrap (truncate)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
i_flag  input  1  core result valid, one-cycle strobe per result
i_mode  input  2  00 MUL, 01 DIV, 10 SQRT, 11 reserved; sampled with i_flag
i_data  input  2*DW+1  signed raw result; bit 0 is the guard bit and is always discarded
i_div_zero  input  1  DIV divisor was zero; sampled with i_flag
i_ack  input  1  consumer accepts head entry
o_ready  output  1  head entry valid
o_data  output  DW  formatted primary result (product / quotient / root)
o_rem  output  DW  secondary result (product high word / remainder)
o_ovf  output  1  MUL result did not fit DW signed bits
o_dbz  output  1  DIV by zero
o_full  output  1  FIFO holds DEPTH entries; core must stall
o_count  output  $clog2(DEPTH+1)  occupancy
o_err  output  1  sticky: result dropped or reserved mode received

Behaviour:
- Reset: o_ready=0, o_data=0, o_rem=0, o_ovf=0, o_dbz=0, o_full=0, o_count=0, o_err=0. Reset is asynchronous and takes effect immediately, including mid-operation; all queued entries are discarded.
- Formatting (combinational, before push); P = i_data[2*DW:1] (2*DW bits, signed):
  - MUL:
    - ovf = 1 when P[2*DW-1:DW-1] is not all-equal.
    - o_data = P[DW-1:0] when ovf = 0 or SAT_EN = 0.
    - When ovf = 1 and SAT_EN = 1: o_data = 0x7FF..F if P[2*DW-1] = 0, else 0x800..0.
    - o_rem = P[2*DW-1:DW]. dbz = 0.
  - DIV:
    - o_data = i_data[DW:1]; o_rem = i_data[2*DW:DW+1]; ovf = 0.
    - When i_div_zero = 1: dbz = 1 and o_data = all-ones. o_rem passes through.
  - SQRT: o_data = i_data[DW:1] (unsigned root); o_rem = i_data[2*DW:DW+1]; ovf = 0; dbz = 0.
  - Reserved mode (11): nothing is pushed; o_err is set.
- Push: i_flag = 1, mode not reserved, and (count < DEPTH or pop in the same cycle).
  - An i_flag that fails this condition drops its result and sets o_err.
- Pop: o_ready = 1 and i_ack = 1. i_ack while o_ready = 0 is ignored.
- Latency: with an empty FIFO, the entry appears on the outputs in the cycle after i_flag (registered head). Entries are delivered strictly in FIFO order.
- Simultaneous push and pop:
  - When full: the push is accepted and count stays at DEPTH.
  - When holding one entry: the next entry becomes head in the following cycle and o_ready stays 1.
- Pointers wrap modulo DEPTH. o_count is always the exact occupancy. o_full = (count == DEPTH).
- Output stability: o_data, o_rem, o_ovf and o_dbz stay stable while o_ready = 1 and i_ack = 0. When the FIFO is empty they hold their last values and o_ready = 0.
- o_err is cleared only by reset.

Test Plan:
1. MUL 6*7: i_data = (42<<1)|1, i_mode = 00, i_flag pulse -> next cycle o_ready = 1, o_data = 42, o_rem = 0, o_ovf = 0; i_ack -> o_ready = 0, o_count = 0.
2. MUL overflow, SAT_EN = 1:
   - P = 0x1_0000_0000 -> o_data = 0x7FFFFFFF, o_ovf = 1, o_rem = 0x00000001.
   - P = -0x1_0000_0000 -> o_data = 0x80000000, o_ovf = 1.
   - With SAT_EN = 0, the positive case gives o_data = 0x00000000, o_ovf = 1.
3. DIV:
   - Quotient 5, remainder 3 -> o_data = 5, o_rem = 3, o_dbz = 0.
   - Same stimulus with i_div_zero = 1 -> o_data = 0xFFFFFFFF, o_dbz = 1.
4. Back-pressure, DEPTH = 2, i_ack = 0: push A, B, C on consecutive cycles -> o_full = 1 after B, C dropped, o_err = 1. Then i_ack = 1 -> A then B delivered, and o_count goes 2 -> 1 -> 0.
5. Full with simultaneous i_flag (D) and i_ack -> head advances, D accepted, o_count stays 2, o_err unchanged. Reserved mode pulse -> no push, o_err = 1.
6. Assert rst mid-stream with o_count = 2 -> in the same cycle, before the clock edge: o_ready = 0, o_count = 0, o_err = 0, o_data = 0. After rst deasserts, a fresh MUL result is delivered normally.
